// File: rtl/pulse_width_encoder_pkg.sv
// Shared constants and controller-visible settings for the intensity-to-pulse-width encoder.
package pulse_width_encoder_pkg;

  localparam int         PWE_TABLE_ADDR_WIDTH = 15;
  localparam logic [8:0] PWE_FULL_WIDTH       = 9'd256;
  localparam int         PWE_LATENCY          = 3;

  typedef struct packed {
    logic [15:0] full_width_start;
  } pulse_width_encoder_settings_t;

  localparam pulse_width_encoder_settings_t PWE_SETTINGS_RESET = '{full_width_start: 16'hFFFF};

endpackage

// File: rtl/pulse_width_encoder_table_bram.sv
// Intensity-to-width lookup RAM: one write port, one registered read-first read port.
module pwe_table_bram
  import pulse_width_encoder_pkg::*;
#(
  parameter int ADDR_W = PWE_TABLE_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];
  logic [7:0] rd_q;

  // Both updates are non-blocking, so a same-address read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_q <= mem[raddr];
  end

  assign rdata = rd_q;

endmodule

// File: rtl/pulse_width_encoder.sv
// Converts a burst of silenced intensities into 9-bit PWM widths via a host-loaded table,
// carrying phase and transducer index alongside with a fixed three-cycle latency.
module pulse_width_encoder
  import pulse_width_encoder_pkg::*;
#(
  parameter int DEPTH = 249
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DIN_VALID,
  input  logic [15:0] INTENSITY_IN,
  input  logic [7:0]  PHASE_IN,
  input  logic [15:0] FULL_WIDTH_START,
  input  logic        TBL_WE,
  input  logic [14:0] TBL_ADDR,
  input  logic [7:0]  TBL_DIN,
  output logic        DOUT_VALID,
  output logic [8:0]  PULSE_WIDTH_OUT,
  output logic [7:0]  PHASE_OUT,
  output logic [7:0]  DOUT_IDX,
  output logic        BUSY
);

  localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

  function automatic logic [8:0] pulse_width(input logic full, input logic [7:0] tbl_word);
    return full ? PWE_FULL_WIDTH : {1'b0, tbl_word};
  endfunction

  logic [7:0] rd_data;

  logic [7:0]                    in_idx_q, in_idx_d;
  pulse_width_encoder_settings_t thr_q, thr_d;
  logic [1:0]                    pending_q, pending_d;
  logic                          busy_q, busy_d;
  logic                          accept_first, burst_done;

  logic        vld_p1_q, vld_p1_d;
  logic [15:0] int_p1_q, int_p1_d;
  logic [7:0]  phase_p1_q, phase_p1_d;
  logic [7:0]  idx_p1_q, idx_p1_d;

  logic        vld_p2_q, vld_p2_d;
  logic        full_p2_q, full_p2_d;
  logic [7:0]  tbl_p2_q, tbl_p2_d;
  logic [7:0]  phase_p2_q, phase_p2_d;
  logic [7:0]  idx_p2_q, idx_p2_d;

  logic        vld_p3_q, vld_p3_d;
  logic [8:0]  pw_p3_q, pw_p3_d;
  logic [7:0]  phase_p3_q, phase_p3_d;
  logic [7:0]  idx_p3_q, idx_p3_d;

  pwe_table_bram #(.ADDR_W(PWE_TABLE_ADDR_WIDTH)) u_table (
    .clk   (CLK),
    .we    (TBL_WE),
    .waddr (TBL_ADDR),
    .wdata (TBL_DIN),
    .raddr (INTENSITY_IN[15:1]),
    .rdata (rd_data)
  );

  always_comb begin
    accept_first = DIN_VALID && (in_idx_q == 8'd0);
    burst_done   = vld_p3_q && (idx_p3_q == LAST_IDX);

    in_idx_d = in_idx_q;
    if (DIN_VALID) begin
      in_idx_d = (in_idx_q == LAST_IDX) ? 8'd0 : in_idx_q + 8'd1;
    end

    thr_d = thr_q;
    if (accept_first) begin
      thr_d.full_width_start = FULL_WIDTH_START;
    end

    // Counts bursts started but not yet fully emitted, so overlapping bursts keep BUSY high.
    pending_d = pending_q + {1'b0, accept_first} - {1'b0, burst_done};
    busy_d    = (pending_d != 2'd0);

    // S1: capture element; the RAM samples the read address on the same edge
    vld_p1_d   = DIN_VALID;
    int_p1_d   = INTENSITY_IN;
    phase_p1_d = PHASE_IN;
    idx_p1_d   = in_idx_q;

    // S2: registered table word and threshold compare
    vld_p2_d   = vld_p1_q;
    full_p2_d  = (int_p1_q >= thr_q.full_width_start);
    tbl_p2_d   = rd_data;
    phase_p2_d = phase_p1_q;
    idx_p2_d   = idx_p1_q;

    // S3: output select, held across gaps
    vld_p3_d   = vld_p2_q;
    pw_p3_d    = pw_p3_q;
    phase_p3_d = phase_p3_q;
    idx_p3_d   = idx_p3_q;
    if (vld_p2_q) begin
      pw_p3_d    = pulse_width(full_p2_q, tbl_p2_q);
      phase_p3_d = phase_p2_q;
      idx_p3_d   = idx_p2_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      in_idx_q   <= 8'd0;
      thr_q      <= PWE_SETTINGS_RESET;
      pending_q  <= 2'd0;
      busy_q     <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      vld_p3_q   <= 1'b0;
      pw_p3_q    <= 9'd0;
      phase_p3_q <= 8'd0;
      idx_p3_q   <= 8'd0;
    end else begin
      in_idx_q   <= in_idx_d;
      thr_q      <= thr_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      vld_p3_q   <= vld_p3_d;
      pw_p3_q    <= pw_p3_d;
      phase_p3_q <= phase_p3_d;
      idx_p3_q   <= idx_p3_d;
    end
  end

  always_ff @(posedge CLK) begin
    int_p1_q   <= int_p1_d;
    phase_p1_q <= phase_p1_d;
    idx_p1_q   <= idx_p1_d;
    full_p2_q  <= full_p2_d;
    tbl_p2_q   <= tbl_p2_d;
    phase_p2_q <= phase_p2_d;
    idx_p2_q   <= idx_p2_d;
  end

  assign DOUT_VALID      = vld_p3_q;
  assign PULSE_WIDTH_OUT = pw_p3_q;
  assign PHASE_OUT       = phase_p3_q;
  assign DOUT_IDX        = idx_p3_q;
  assign BUSY            = busy_q;

endmodule

// File: tb/tb_pulse_width_encoder.sv
// Randomized bench for pulse_width_encoder against a queue-based reference model.
module tb_pulse_width_encoder;

  localparam int DEPTH = 249;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        DIN_VALID;
  logic [15:0] INTENSITY_IN;
  logic [7:0]  PHASE_IN;
  logic [15:0] FULL_WIDTH_START;
  logic        TBL_WE;
  logic [14:0] TBL_ADDR;
  logic [7:0]  TBL_DIN;
  logic        DOUT_VALID;
  logic [8:0]  PULSE_WIDTH_OUT;
  logic [7:0]  PHASE_OUT;
  logic [7:0]  DOUT_IDX;
  logic        BUSY;

  always #5 clk = ~clk;

  pulse_width_encoder #(.DEPTH(DEPTH)) dut (
    .CLK              (clk),
    .RST_N            (RST_N),
    .DIN_VALID        (DIN_VALID),
    .INTENSITY_IN     (INTENSITY_IN),
    .PHASE_IN         (PHASE_IN),
    .FULL_WIDTH_START (FULL_WIDTH_START),
    .TBL_WE           (TBL_WE),
    .TBL_ADDR         (TBL_ADDR),
    .TBL_DIN          (TBL_DIN),
    .DOUT_VALID       (DOUT_VALID),
    .PULSE_WIDTH_OUT  (PULSE_WIDTH_OUT),
    .PHASE_OUT        (PHASE_OUT),
    .DOUT_IDX         (DOUT_IDX),
    .BUSY             (BUSY)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: every accepted element becomes one expected output, due two edges later.
  typedef struct {
    int due;
    int pw;
    int ph;
    int idx;
  } exp_t;

  logic [7:0] tbl_m [32768];
  exp_t       q[$];
  exp_t       shown;
  exp_t       e;
  bit         shown_v = 0;
  bit         chk_en = 0;
  int         edge_n = 0;
  int         m_idx = 0;
  int         m_thr = 65535;
  int         starts = 0;
  int         ends = 0;

  always @(posedge clk) begin
    edge_n++;
    if (!RST_N) begin
      q.delete();
      shown_v = 0;
      m_idx   = 0;
      m_thr   = 65535;
      starts  = 0;
      ends    = 0;
    end else begin
      if (shown_v && shown.idx == DEPTH - 1) ends++;
      if (DIN_VALID) begin
        if (m_idx == 0) begin
          m_thr = int'(FULL_WIDTH_START);
          starts++;
        end
        e.due = edge_n + 2;
        e.pw  = (int'(INTENSITY_IN) >= m_thr) ? 256 : int'(tbl_m[INTENSITY_IN >> 1]);
        e.ph  = int'(PHASE_IN);
        e.idx = m_idx;
        q.push_back(e);
        m_idx = (m_idx + 1) % DEPTH;
      end
      shown_v = 0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        shown   = q.pop_front();
        shown_v = 1;
      end
    end
    if (TBL_WE) tbl_m[TBL_ADDR] = TBL_DIN;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout_valid", DOUT_VALID, shown_v);
      if (shown_v) begin
        chk("pulse_width", PULSE_WIDTH_OUT, shown.pw);
        chk("phase", PHASE_OUT, shown.ph);
        chk("dout_idx", DOUT_IDX, shown.idx);
      end
      chk("busy", BUSY, (starts > ends));
    end
  end

  int cyc = 0;

  task automatic drv(input logic v, input logic [15:0] it, input logic [7:0] ph,
                     input logic we, input logic [14:0] a, input logic [7:0] d);
    DIN_VALID    = v;
    INTENSITY_IN = it;
    PHASE_IN     = ph;
    TBL_WE       = we;
    TBL_ADDR     = a;
    TBL_DIN      = d;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, DOUT_VALID, 0);
    chk({tag, "_pw"}, PULSE_WIDTH_OUT, 0);
    chk({tag, "_phase"}, PHASE_OUT, 0);
    chk({tag, "_idx"}, DOUT_IDX, 0);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  // gap_mode: 0 none, 1 every third cycle idle, 2 random idles.
  // pat: 0 identity ramp, 1 random with random table writes, 2 threshold edge, 3 write collision.
  task automatic burst(input int gap_mode, input int pat, input int reset_at);
    int          i;
    logic [15:0] it;
    logic [7:0]  ph;
    logic        we;
    logic [14:0] a;
    logic [7:0]  d;
    i = 0;
    while (i < DEPTH) begin
      if ((gap_mode == 1 && cyc % 3 == 2) || (gap_mode == 2 && $urandom_range(3) == 0)) begin
        drv(1'b0, 16'($urandom), 8'($urandom), 1'b0, 15'd0, 8'd0);
      end else if (i == reset_at) begin
        RST_N = 1'b0;
        drv(1'b0, 16'd0, 8'd0, 1'b0, 15'd0, 8'd0);
        RST_N = 1'b1;
        check_reset_state("midrst");
        return;
      end else begin
        it = 16'($urandom);
        ph = 8'($urandom);
        we = 1'b0;
        a  = 15'd0;
        d  = 8'd0;
        case (pat)
          0: begin
            it = 16'(2 * i);
            ph = 8'(i);
          end
          1: begin
            if (i == 0) it = 16'd0;
            if ($urandom_range(15) == 0) begin
              we = 1'b1;
              a  = 15'($urandom);
              d  = 8'($urandom);
            end
          end
          2: begin
            case (i)
              0: it = 16'd998;
              1: it = 16'd999;
              2: it = 16'd1000;
              3: it = 16'd65535;
              default: ;
            endcase
            if (i == 100) FULL_WIDTH_START = 16'd0;
          end
          3: begin
            it = 16'($urandom_range(65534));
            if (i == 10 || i == 11) it = 16'd10;
            if (i == 10) begin
              we = 1'b1;
              a  = 15'd5;
              d  = 8'd77;
            end
          end
          default: ;
        endcase
        drv(1'b1, it, ph, we, a, d);
        i++;
      end
    end
  endtask

  initial begin
    RST_N            = 1'b0;
    FULL_WIDTH_START = 16'hFFFF;
    for (int k = 0; k < 3; k++) drv(1'b0, 16'd0, 8'd0, 1'b0, 15'd0, 8'd0);
    check_reset_state("reset");
    RST_N  = 1'b1;
    chk_en = 1;

    for (int a = 0; a < 32768; a++) drv(1'b0, 16'd0, 8'd0, 1'b1, 15'(a), 8'(a));

    burst(0, 0, -1);
    for (int k = 0; k < 5; k++) drv(1'b0, 16'd0, 8'd0, 1'b0, 15'd0, 8'd0);

    FULL_WIDTH_START = 16'd1000;
    burst(0, 2, -1);
    burst(2, 1, -1);
    for (int k = 0; k < 5; k++) drv(1'b0, 16'd0, 8'd0, 1'b0, 15'd0, 8'd0);

    FULL_WIDTH_START = 16'($urandom);
    burst(1, 1, -1);
    FULL_WIDTH_START = 16'($urandom);
    burst(1, 1, -1);
    for (int k = 0; k < 5; k++) drv(1'b0, 16'd0, 8'd0, 1'b0, 15'd0, 8'd0);

    FULL_WIDTH_START = 16'($urandom);
    burst(0, 1, 50);
    FULL_WIDTH_START = 16'hFFFF;
    burst(2, 0, -1);
    for (int k = 0; k < 5; k++) drv(1'b0, 16'd0, 8'd0, 1'b0, 15'd0, 8'd0);

    drv(1'b0, 16'd0, 8'd0, 1'b1, 15'd5, 8'd3);
    burst(0, 3, -1);
    for (int k = 0; k < 6; k++) drv(1'b0, 16'd0, 8'd0, 1'b0, 15'd0, 8'd0);

    chk("drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
